// File: rtl/axi_wr_arbiter_if.sv
// Bundle of AW request, W-route and B-completion signals around one master-port write arbiter.
interface axi_wr_arbiter_if #(
    parameter int S_COUNT = 4,
    parameter int ISSUE   = 4
);
    localparam int SEL_W = $clog2(S_COUNT);
    localparam int CNT_W = $clog2(ISSUE + 1);

    logic [S_COUNT-1:0]   req_valid;
    logic [S_COUNT*4-1:0] req_qos;
    logic [S_COUNT-1:0]   req_ready;
    logic                 m_aw_valid;
    logic                 m_aw_ready;
    logic [SEL_W-1:0]     m_aw_sel;
    logic [SEL_W-1:0]     w_sel;
    logic                 w_sel_valid;
    logic                 w_beat;
    logic                 w_last;
    logic                 b_done;
    logic [CNT_W-1:0]     outstanding;

    // master: the arbiter; slave: the crossbar stages around it
    modport master (
        input  req_valid, req_qos, m_aw_ready, w_beat, w_last, b_done,
        output req_ready, m_aw_valid, m_aw_sel, w_sel, w_sel_valid, outstanding
    );

    modport slave (
        output req_valid, req_qos, m_aw_ready, w_beat, w_last, b_done,
        input  req_ready, m_aw_valid, m_aw_sel, w_sel, w_sel_valid, outstanding
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AW arbiter with in-order W routing FIFO and outstanding-write limit.
// Optional macro AXI_WR_ARB_QOS_EN restricts round-robin to the highest-QoS valid requesters.
//
// state | meaning
// IDLE  | no grant held; arbitrate when a slot and a W-route entry are free
// GRANT | winner presented on master AW until awready
module axi_wr_arbiter #(
    parameter int S_COUNT      = 4,
    parameter int ISSUE        = 4,
    parameter int W_FIFO_DEPTH = 4,
    parameter int SEL_W        = $clog2(S_COUNT),
    parameter int CNT_W        = $clog2(ISSUE + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    axi_wr_arbiter_if.master   bus
);
    localparam int PTR_W = $clog2(W_FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   grant, last_grant, winner, idx_sel;
    logic [CNT_W-1:0]   outstanding;
    logic [SEL_W-1:0]   fifo_mem [W_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               aw_hs, push, pop, dec, issue_ok, start, found;
    logic [S_COUNT-1:0] cand;
    int                 idx;

`ifdef AXI_WR_ARB_QOS_EN
    logic [3:0] qos_max;

    always_comb begin
        qos_max = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (bus.req_valid[i] && (bus.req_qos[4*i +: 4] > qos_max))
                qos_max = bus.req_qos[4*i +: 4];
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < S_COUNT; i++)
            cand[i] = bus.req_valid[i] && (bus.req_qos[4*i +: 4] == qos_max);
    end
`else
    logic unused_qos;
    assign unused_qos = ^bus.req_qos;
    assign cand       = bus.req_valid;
`endif

    // first candidate searching upward from last_grant+1, wrapping
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        idx_sel = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            idx     = (int'(last_grant) + k) % S_COUNT;
            idx_sel = SEL_W'(idx);
            if (!found && cand[idx_sel]) begin
                found  = 1'b1;
                winner = idx_sel;
            end
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(W_FIFO_DEPTH));
    assign issue_ok   = (outstanding < CNT_W'(ISSUE));
    assign start      = (state == IDLE) && (|bus.req_valid) && issue_ok && !fifo_full;
    assign aw_hs      = (state == GRANT) && bus.m_aw_ready;
    assign push       = aw_hs;
    assign pop        = bus.w_beat && bus.w_last && !fifo_empty;
    assign dec        = bus.b_done && (outstanding != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = GRANT;
            GRANT:   if (aw_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_aw_valid = (state == GRANT);
        bus.m_aw_sel   = grant;
        bus.req_ready  = '0;
        if (state == GRANT)
            bus.req_ready = {{(S_COUNT-1){1'b0}}, bus.m_aw_ready} << grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant       <= '0;
            last_grant  <= SEL_W'(S_COUNT - 1);
            outstanding <= '0;
        end else begin
            if (start) grant <= winner;
            if (aw_hs) last_grant <= grant;
            case ({aw_hs, dec})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < W_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= grant;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign bus.w_sel_valid = !fifo_empty;
    assign bus.w_sel       = fifo_mem[rd_ptr];
    assign bus.outstanding = outstanding;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: cycle model of grant/issue state plus a W-route scoreboard queue.
module tb_axi_wr_arbiter;
    localparam int S   = 4;
    localparam int ISS = 4;
    localparam int D   = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.S_COUNT(S), .ISSUE(ISS)) bus ();

    axi_wr_arbiter #(.S_COUNT(S), .ISSUE(ISS), .W_FIFO_DEPTH(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    bit m_state;
    int m_grant, m_last, m_out;
    int wq[$];
    int hs_log[$];
    int hs_cyc[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [S-1:0] v, input logic [4*S-1:0] q, input int last);
        logic [S-1:0] c;
        int mx, i;
        c  = v;
        mx = 0;
`ifdef AXI_WR_ARB_QOS_EN
        for (int j = 0; j < S; j++) if (v[j] && int'(q[4*j +: 4]) > mx) mx = int'(q[4*j +: 4]);
        for (int j = 0; j < S; j++) c[j] = v[j] && (int'(q[4*j +: 4]) == mx);
`endif
        for (int k = 1; k <= S; k++) begin
            i = (last + k) % S;
            if (c[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) cyc++;

    // reference model, advanced on the same edge as the DUT
    always @(posedge clk or negedge rstn) begin
        bit hs, pop, full, ok;
        if (!rstn) begin
            m_state = 1'b0;
            m_grant = 0;
            m_last  = S - 1;
            m_out   = 0;
            wq.delete();
        end else begin
            hs   = m_state && bus.m_aw_ready;
            pop  = bus.w_beat && bus.w_last && (wq.size() > 0);
            full = (wq.size() >= D);
            ok   = !m_state && (|bus.req_valid) && (m_out < ISS) && !full;
            if (pop) void'(wq.pop_front());
            if (hs && !(bus.b_done && m_out > 0)) m_out++;
            else if (!hs && bus.b_done && m_out > 0) m_out--;
            if (hs) begin
                wq.push_back(m_grant);
                m_last  = m_grant;
                m_state = 1'b0;
            end else if (ok) begin
                m_grant = rr_pick(bus.req_valid, bus.req_qos, m_last);
                m_state = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            chk("aw_valid", int'(bus.m_aw_valid), int'(m_state));
            chk("outstanding", int'(bus.outstanding), m_out);
            chk("w_sel_valid", int'(bus.w_sel_valid), int'(wq.size() != 0));
            if (m_state) begin
                chk("aw_sel", int'(bus.m_aw_sel), m_grant);
                chk("req_ready", int'(bus.req_ready), bus.m_aw_ready ? (1 << m_grant) : 0);
                if (bus.m_aw_ready) begin
                    hs_log.push_back(int'(bus.m_aw_sel));
                    hs_cyc.push_back(cyc);
                end
            end else begin
                chk("req_ready_idle", int'(bus.req_ready), 0);
            end
            if (bus.w_beat && bus.w_last && wq.size() > 0)
                chk("w_route", int'(bus.w_sel), wq[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [S-1:0] v, input bit rdy, input bit wl, input bit bd);
        bus.req_valid  = v;
        bus.m_aw_ready = rdy;
        bus.w_beat     = wl;
        bus.w_last     = wl;
        bus.b_done     = bd;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_in('0, 1'b0, 1'b0, 1'b0);
        bus.req_qos = '0;
        tick(2);
        rstn = 1'b1;
        hs_log.delete();
        hs_cyc.delete();
    endtask

    initial begin
        set_in('0, 1'b0, 1'b0, 1'b0);
        bus.req_qos = '0;
        #1;
        chk("rst_aw_valid", int'(bus.m_aw_valid), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_w_sel_valid", int'(bus.w_sel_valid), 0);
        chk("rst_outstanding", int'(bus.outstanding), 0);
        chk("rst_aw_sel", int'(bus.m_aw_sel), 0);
        chk("rst_w_sel", int'(bus.w_sel), 0);
        mon_en = 1'b1;

        // basic round-robin, one handshake every two cycles
        do_reset();
        set_in(4'b1111, 1'b1, 1'b1, 1'b1);
        tick(11);
        chk("rr_count", int'(hs_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++) chk("rr_order", hs_log[i], i % 4);
        for (int i = 1; i < 5; i++) chk("rr_gap", hs_cyc[i] - hs_cyc[i-1], 2);

        // issue limit
        do_reset();
        set_in(4'b1111, 1'b1, 1'b1, 1'b0);
        tick(14);
        chk("issue_count", hs_log.size(), 4);
        chk("issue_stall", int'(bus.m_aw_valid), 0);
        chk("issue_out", int'(bus.outstanding), 4);
        bus.b_done = 1'b1;
        tick(1);
        bus.b_done = 1'b0;
        tick(6);
        chk("issue_one_more", hs_log.size(), 5);
        chk("issue_out_again", int'(bus.outstanding), 4);
        chk("issue_stall2", int'(bus.m_aw_valid), 0);
        chk("issue_fifth_sel", hs_log[4], 0);

        // W-route FIFO full
        do_reset();
        set_in(4'b1111, 1'b1, 1'b0, 1'b1);
        bus.w_beat = 1'b1;
        tick(14);
        chk("full_count", hs_log.size(), 4);
        chk("full_stall", int'(bus.m_aw_valid), 0);
        chk("full_head", int'(bus.w_sel), 0);
        bus.w_last = 1'b1;
        tick(1);
        bus.w_last = 1'b0;
        chk("pop_not_yet", int'(bus.m_aw_valid), 0);
        chk("pop_head", int'(bus.w_sel), 1);
        tick(1);
        chk("pop_rearb", int'(bus.m_aw_valid), 1);
        chk("pop_rearb_sel", int'(bus.m_aw_sel), 0);
        bus.req_valid = '0;
        bus.w_last    = 1'b1;
        tick(8);
        chk("drain_empty", int'(bus.w_sel_valid), 0);

        // simultaneous AW handshake and b_done; b_done at zero
        do_reset();
        set_in(4'b0001, 1'b0, 1'b1, 1'b0);
        tick(1);
        bus.m_aw_ready = 1'b1; tick(1);
        bus.m_aw_ready = 1'b0; tick(1);
        bus.m_aw_ready = 1'b1; tick(1);
        bus.m_aw_ready = 1'b0; tick(1);
        chk("sim_pre", int'(bus.outstanding), 2);
        bus.m_aw_ready = 1'b1;
        bus.b_done     = 1'b1;
        tick(1);
        chk("sim_hold", int'(bus.outstanding), 2);
        bus.req_valid = '0;
        tick(3);
        chk("sim_drain", int'(bus.outstanding), 0);
        tick(1);
        chk("sim_floor", int'(bus.outstanding), 0);

        // asynchronous reset while granting with two routes queued
        do_reset();
        set_in(4'b1111, 1'b1, 1'b0, 1'b0);
        tick(4);
        bus.m_aw_ready = 1'b0;
        tick(1);
        bus.m_aw_ready = 1'b1;
        #1;
        chk("pre_rst_ready", int'(bus.req_ready), 4);
        chk("pre_rst_wvalid", int'(bus.w_sel_valid), 1);
        rstn = 1'b0;
        #1;
        chk("arst_aw_valid", int'(bus.m_aw_valid), 0);
        chk("arst_req_ready", int'(bus.req_ready), 0);
        chk("arst_w_sel_valid", int'(bus.w_sel_valid), 0);
        chk("arst_outstanding", int'(bus.outstanding), 0);
        chk("arst_aw_sel", int'(bus.m_aw_sel), 0);
        chk("arst_w_sel", int'(bus.w_sel), 0);
        #2;
        rstn = 1'b1;
        tick(1);
        chk("post_rst_valid", int'(bus.m_aw_valid), 1);
        chk("post_rst_sel", int'(bus.m_aw_sel), 0);

        // QoS: requester 1 at 5, requester 3 at 9
        do_reset();
        bus.req_qos = 16'h9050;
        set_in(4'b1010, 1'b1, 1'b1, 1'b1);
        tick(10);
        chk("qos_count", int'(hs_log.size() >= 4), 1);
`ifdef AXI_WR_ARB_QOS_EN
        for (int i = 0; i < 4; i++) chk("qos_win", hs_log[i], 3);
`else
        for (int i = 0; i < 4; i++) chk("rr_alt", hs_log[i], (i % 2 == 0) ? 1 : 3);
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

- Sequences one crossbar master port's write path between `S_COUNT` slave-side requesters.
- Arbitration:
  - Round-robin arbitration on the AW channel.
  - W-channel routing is held to each winner, in AW order, until its `wlast` beat.
  - Write transactions in flight are limited by an issue counter; each B completion decrements it.
- Position in the design: between the crossbar's per-slave AW/W input stages and each master-port output register.

## Interface
Parameters:
- `S_COUNT`, 4, number of requesters; must be ≥ 2.
- `ISSUE`, 4, maximum outstanding write transactions; must be ≥ 1.
- `W_FIFO_DEPTH`, 4, W-route FIFO entries; power of two, ≥ 2.
- `SEL_W`, `$clog2(S_COUNT)`, select width; derived, do not override.
- `CNT_W`, `$clog2(ISSUE+1)`, counter width; derived, do not override.

Ports:
- `clk`  in  1  clock; all logic rises on posedge.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  `S_COUNT`  per-requester `awvalid`.
- `req_qos`  in  `S_COUNT*4`  per-requester `awqos`; requester i occupies bits [4i+3:4i].
- `req_ready`  out  `S_COUNT`  per-requester `awready`.
- `m_aw_valid`  out  1  `awvalid` to the master port.
- `m_aw_ready`  in  1  `awready` from the master port.
- `m_aw_sel`  out  `SEL_W`  index of the requester driving the master AW mux.
- `w_sel`  out  `SEL_W`  index of the requester driving the master W mux.
- `w_sel_valid`  out  1  `w_sel` is meaningful; the W mux is enabled.
- `w_beat`  in  1  master-side W handshake (`wvalid & wready`).
- `w_last`  in  1  `wlast` of the current W beat.
- `b_done`  in  1  master-side B handshake (`bvalid & bready`).
- `outstanding`  out  `CNT_W`  current issue count.

## Operation
- State machine: `IDLE` and `GRANT`.
- `IDLE` → `GRANT` when all of the following hold:
  - `|req_valid` is true.
  - `outstanding < ISSUE`.
  - The W FIFO is not full.
- On that transition the winner is registered into `grant`.
- Winner selection: the first valid requester found searching upward from `last_grant+1`, wrapping modulo `S_COUNT`.
- In `GRANT`:
  - `m_aw_valid = 1`.
  - `m_aw_sel = grant`.
  - `req_ready = m_aw_ready << grant`, combinational; all other bits are 0.
- `GRANT` → `IDLE` on `m_aw_valid & m_aw_ready`. On that cycle:
  - `grant` is pushed into the W FIFO.
  - `outstanding` increments.
  - `last_grant` is updated to `grant`.
- Grant is held until handshake. If the winner deasserts `req_valid` (an AXI violation), `m_aw_valid` stays high.
- W FIFO outputs:
  - `w_sel_valid = !empty`.
  - `w_sel = head`.
  - Pop on `w_beat & w_last`.
  - A `w_beat` while empty is ignored.
- `outstanding` update rules:
  - `+1` on AW handshake.
  - `−1` on `b_done`.
  - Both in the same cycle leaves it unchanged.
  - `b_done` at 0 is ignored; the counter saturates at 0 and never wraps.
- FIFO simultaneous push and pop (possible only when not full): occupancy is unchanged and the head advances correctly.
- Full FIFO or `outstanding == ISSUE`: no new arbitration. A grant already in `GRANT` still completes, because the checks were made at entry.

## Timing
- Reset values:
  - State `IDLE`.
  - `m_aw_valid`, `req_ready`, `w_sel_valid`, `outstanding`, `m_aw_sel`, `w_sel` all 0.
  - `last_grant = S_COUNT-1`, so requester 0 wins first.
  - FIFO empty.
- Reset is asynchronous. Asserting it mid-burst clears all state immediately; in-flight transactions are abandoned.
- Arbitration latency:
  - A request valid in `IDLE` at edge n gives `m_aw_valid = 1` after edge n.
  - Best case is one AW handshake every 2 cycles.
- Push-to-visible latency: the W route becomes visible (`w_sel_valid`) in the cycle after the AW handshake edge. W beats arriving earlier are stalled externally.
- `req_ready` has a combinational path from `m_aw_ready`. There is no combinational path from `req_valid` to any output.

## Configuration
- Macro: `AXI_WR_ARB_QOS_EN`.
- Defined:
  - The candidate set is restricted to valid requesters whose `req_qos` equals the maximum `req_qos` among valid requesters.
  - Round-robin from `last_grant+1` applies within that set.
- Undefined: `req_qos` is ignored (the port remains) and arbitration is pure round-robin.

## Test plan
- Basic grant and route: `req_valid=4'b1111`, `m_aw_ready=1` held.
  - Required: grants 0,1,2,3,0 on successive handshakes every 2 cycles.
  - Required: `w_sel` sequence matches, with one pop per `w_last`.
- Issue limit: `ISSUE=4`, no `b_done`, continuous requests.
  - Required: exactly 4 AW handshakes, then `m_aw_valid` stays 0.
  - Then one `b_done` → exactly one further grant; `outstanding` returns to 4.
- W-route FIFO full: `W_FIFO_DEPTH=4`, no `w_last`.
  - Required: arbitration stops after 4 pushes.
  - A pop on `w_beat & w_last` re-enables arbitration next cycle.
  - `w_sel` order equals AW order.
- Simultaneous events: AW handshake and `b_done` in the same cycle with `outstanding=2` → `outstanding` stays 2. `b_done` at 0 → stays 0.
- Reset mid-operation: `rstn` low while in `GRANT` with 2 FIFO entries.
  - Required: outputs 0 asynchronously.
  - After release, requester 0 wins first.
- QoS: with `AXI_WR_ARB_QOS_EN`, req 1 qos=5, req 3 qos=9, both valid.
  - Required: 3 wins repeatedly.
  - Without the macro: alternates 1,3.
